flappy_game_ctrl: RTL and testbench

Top-level game sequencer for the Flappy Bird datapath. It runs the round lifecycle: idle, countdown, running, dying, game over. It converts the per-video-frame tick into physics step and pipe-spawn strobes, and it qualifies the player's flap input. It also keeps the current score and the high score, and raises done. It sits between the input/VGA timing logic and the bird/pipe/collision datapath.

---
 rtl/flappy_game_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_flappy_game_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flappy_game_ctrl.sv
// Round sequencer for the Flappy Bird datapath: lifecycle FSM, frame-to-step/spawn strobes, flap qualification, scoring.
// Optional pause: define PAUSE_TOGGLE_EN to let start toggle RUNNING <-> PAUSED.
module flappy_game_ctrl #(
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int DEATH_FRAMES     = 60,
   parameter int FRAMES_PER_STEP  = 2,
   parameter int SPAWN_FRAMES     = 90,
   parameter int SCORE_W          = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               flap,
   input  logic               collision,
   input  logic               pipe_passed,
   output logic [2:0]         state,
   output logic               clear_field,
   output logic               step,
   output logic               flap_cmd,
   output logic               spawn_pipe,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               done
);

   localparam int FMAX = (COUNTDOWN_FRAMES > DEATH_FRAMES) ?
                         COUNTDOWN_FRAMES : DEATH_FRAMES;
   localparam int FW   = $clog2(FMAX + 1);
   localparam int SW   = $clog2(FRAMES_PER_STEP + 1);
   localparam int PW   = $clog2(SPAWN_FRAMES + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_RUNNING   = 3'd2,
      S_DYING     = 3'd3,
      S_OVER      = 3'd4,
      S_PAUSED    = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [FW-1:0]      frame_q, frame_d;
   logic [SW-1:0]      stepc_q, stepc_d;
   logic [PW-1:0]      spawnc_q, spawnc_d;
   logic               pend_q, pend_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] high_q, high_d;
   logic               clear_q, clear_d;
   logic               step_q, step_d;
   logic               fcmd_q, fcmd_d;
   logic               spawn_q, spawn_d;
   logic               done_q, done_d;

   assign state       = state_q;
   assign clear_field = clear_q;
   assign step        = step_q;
   assign flap_cmd    = fcmd_q;
   assign spawn_pipe  = spawn_q;
   assign score       = score_q;
   assign high_score  = high_q;
   assign done        = done_q;

   // Next-state, counter and registered-strobe logic
   always_comb begin
      state_d  = state_q;
      frame_d  = frame_q;
      stepc_d  = stepc_q;
      spawnc_d = spawnc_q;
      pend_d   = pend_q;
      score_d  = score_q;
      high_d   = high_q;
      clear_d  = 1'b0;
      step_d   = 1'b0;
      fcmd_d   = 1'b0;
      spawn_d  = 1'b0;
      unique case (state_q)
         S_IDLE, S_OVER: begin
            if (start) begin
               state_d = S_COUNTDOWN;
               clear_d = 1'b1;
               score_d = '0;
               frame_d = '0;
            end
         end
         S_COUNTDOWN: begin
            if (frame_tick) begin
               if (frame_q == FW'(COUNTDOWN_FRAMES - 1)) begin
                  state_d  = S_RUNNING;
                  stepc_d  = '0;
                  spawnc_d = '0;
                  pend_d   = 1'b0;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         S_RUNNING: begin
            if (collision) begin
               state_d = S_DYING;
               frame_d = '0;
               pend_d  = 1'b0;
            end else begin
               pend_d = pend_q | flap;
               if (frame_tick) begin
                  if (stepc_q == SW'(FRAMES_PER_STEP - 1)) begin
                     stepc_d = '0;
                     step_d  = 1'b1;
                     fcmd_d  = pend_q;
                     pend_d  = flap;
                  end else begin
                     stepc_d = stepc_q + 1'b1;
                  end
                  if (spawnc_q == PW'(SPAWN_FRAMES - 1)) begin
                     spawnc_d = '0;
                     spawn_d  = 1'b1;
                  end else begin
                     spawnc_d = spawnc_q + 1'b1;
                  end
               end
               if (pipe_passed && (score_q != '1))
                  score_d = score_q + 1'b1;
`ifdef PAUSE_TOGGLE_EN
               if (start)
                  state_d = S_PAUSED;
`endif
            end
         end
         S_DYING: begin
            pend_d = 1'b0;
            if (frame_tick) begin
               if (frame_q == FW'(DEATH_FRAMES - 1)) begin
                  state_d = S_OVER;
                  if (score_q > high_q)
                     high_d = score_q;
               end else begin
                  frame_d = frame_q + 1'b1;
               end
            end
         end
         S_PAUSED: begin
`ifdef PAUSE_TOGGLE_EN
            if (start)
               state_d = S_RUNNING;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_OVER);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         frame_q  <= '0;
         stepc_q  <= '0;
         spawnc_q <= '0;
         pend_q   <= 1'b0;
         score_q  <= '0;
         high_q   <= '0;
         clear_q  <= 1'b0;
         step_q   <= 1'b0;
         fcmd_q   <= 1'b0;
         spawn_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         frame_q  <= frame_d;
         stepc_q  <= stepc_d;
         spawnc_q <= spawnc_d;
         pend_q   <= pend_d;
         score_q  <= score_d;
         high_q   <= high_d;
         clear_q  <= clear_d;
         step_q   <= step_d;
         fcmd_q   <= fcmd_d;
         spawn_q  <= spawn_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl with small parameters.
// Define PAUSE_TOGGLE_EN here and in the RTL to exercise the pause path.
module tb_flappy_game_ctrl;
   localparam int SW = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic frame_tick = 1'b0, start = 1'b0, flap = 1'b0;
   logic collision = 1'b0, pipe_passed = 1'b0;
   logic [2:0] state;
   logic clear_field, step, flap_cmd, spawn_pipe, done;
   logic [SW-1:0] score, high_score;

   int n_tests = 0;
   int n_fail = 0;
   int run_ticks = 0;

   typedef struct packed {
      logic clr;
      logic stp;
      logic fcmd;
      logic spw;
   } strb_t;

   strb_t sb[$];
   strb_t got_s;
   strb_t exp_s;

   assign got_s = {clear_field, step, flap_cmd, spawn_pipe};

   always #5 clk = ~clk;

   flappy_game_ctrl #(
      .COUNTDOWN_FRAMES(4),
      .DEATH_FRAMES(3),
      .FRAMES_PER_STEP(2),
      .SPAWN_FRAMES(5),
      .SCORE_W(SW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .frame_tick(frame_tick),
      .start(start),
      .flap(flap),
      .collision(collision),
      .pipe_passed(pipe_passed),
      .state(state),
      .clear_field(clear_field),
      .step(step),
      .flap_cmd(flap_cmd),
      .spawn_pipe(spawn_pipe),
      .score(score),
      .high_score(high_score),
      .done(done)
   );

   task automatic cyc(input logic ft, st, fl, co, pp);
      frame_tick = ft;
      start = st;
      flap = fl;
      collision = co;
      pipe_passed = pp;
      @(posedge clk);
      #1;
      frame_tick = 0;
      start = 0;
      flap = 0;
      collision = 0;
      pipe_passed = 0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) cyc(1, 1, 1, 0, 1);
      n_tests++;
      if (state !== 3'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_state: got %0d/%0b want 0/0", state, done);
      end
      n_tests++;
      if (score !== 0 || high_score !== 0 || got_s !== 4'b0) begin
         n_fail++;
         $display("FAIL rst_regs: got %0d %0d %b want 0 0 0000",
                  score, high_score, got_s);
      end
      reset = 1'b0;
   endtask

   task automatic start_round;
      sb.push_back(strb_t'(4'b1000));
      cyc(0, 1, 0, 0, 0);
      exp_s = sb.pop_front();
      n_tests++;
      if (got_s !== exp_s || state !== 3'd1 || score !== 0 || done !== 0) begin
         n_fail++;
         $display("FAIL start: got %b st%0d sc%0d d%0b want %b st1 sc0 d0",
                  got_s, state, score, done, exp_s);
      end
      repeat (4) cyc(1, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("FAIL enter_run: got %0d want 2", state);
      end
      run_ticks = 0;
   endtask

   task automatic test_countdown;
      sb.push_back(strb_t'(4'b1000));
      cyc(0, 1, 0, 0, 0);
      exp_s = sb.pop_front();
      n_tests++;
      if (got_s !== exp_s || state !== 3'd1) begin
         n_fail++;
         $display("FAIL cd_enter: got %b st%0d want %b st1", got_s, state, exp_s);
      end
      cyc(0, 0, 0, 0, 0);
      n_tests++;
      if (got_s !== 4'b0) begin
         n_fail++;
         $display("FAIL cd_clear_once: got %b want 0000", got_s);
      end
      repeat (3) cyc(1, 1, 1, 1, 0);
      n_tests++;
      if (state !== 3'd1 || got_s !== 4'b0) begin
         n_fail++;
         $display("FAIL cd_hold: got st%0d %b want st1 0000", state, got_s);
      end
      cyc(1, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd2 || score !== 0) begin
         n_fail++;
         $display("FAIL cd_to_run: got st%0d sc%0d want st2 sc0", state, score);
      end
      run_ticks = 0;
   endtask

   task automatic test_strobes;
      int nstep = 0;
      int nspawn = 0;
      for (int k = 0; k < 10; k++) begin
         run_ticks++;
         sb.push_back({1'b0, 1'(run_ticks % 2 == 0), 1'b0,
                       1'(run_ticks % 5 == 0)});
         cyc(1, 0, 0, 0, 0);
         exp_s = sb.pop_front();
         nstep += int'(step);
         nspawn += int'(spawn_pipe);
         n_tests++;
         if (got_s !== exp_s) begin
            n_fail++;
            $display("FAIL strobe_t%0d: got %b want %b", run_ticks, got_s, exp_s);
         end
         cyc(0, 0, 0, 0, 0);
         n_tests++;
         if (got_s !== 4'b0) begin
            n_fail++;
            $display("FAIL strobe_width_t%0d: got %b want 0000", run_ticks, got_s);
         end
      end
      n_tests++;
      if (nstep != 5 || nspawn != 2) begin
         n_fail++;
         $display("FAIL strobe_count: got %0d/%0d want 5/2", nstep, nspawn);
      end
   endtask

   task automatic test_flap;
      bit fls[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
      bit fcs[8] = '{0, 1, 0, 0, 0, 1, 0, 0};
      repeat (3) cyc(0, 0, 1, 0, 0);
      n_tests++;
      if (got_s !== 4'b0) begin
         n_fail++;
         $display("FAIL flap_early: got %b want 0000", got_s);
      end
      for (int k = 0; k < 8; k++) begin
         run_ticks++;
         sb.push_back({1'b0, 1'(run_ticks % 2 == 0), 1'(fcs[k]),
                       1'(run_ticks % 5 == 0)});
         cyc(1, 0, fls[k], 0, 0);
         exp_s = sb.pop_front();
         n_tests++;
         if (got_s !== exp_s) begin
            n_fail++;
            $display("FAIL flap_t%0d: got %b want %b", run_ticks, got_s, exp_s);
         end
      end
   endtask

   task automatic test_score;
      for (int i = 1; i <= 7; i++) begin
         cyc(0, 0, 0, 0, 1);
         n_tests++;
         if (score !== SW'(i)) begin
            n_fail++;
            $display("FAIL score_inc%0d: got %0d want %0d", i, score, i);
         end
      end
      cyc(0, 0, 0, 1, 1);
      n_tests++;
      if (state !== 3'd3 || score !== 3'd7) begin
         n_fail++;
         $display("FAIL collide: got st%0d sc%0d want st3 sc7", state, score);
      end
      repeat (2) cyc(1, 1, 1, 0, 0);
      n_tests++;
      if (state !== 3'd3 || got_s !== 4'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL dying: got st%0d %b d%0b want st3 0000 d0",
                  state, got_s, done);
      end
      cyc(1, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd4 || done !== 1'b1 || high_score !== 3'd7) begin
         n_fail++;
         $display("FAIL over: got st%0d d%0b hi%0d want st4 d1 hi7",
                  state, done, high_score);
      end
   endtask

   task automatic test_round2;
      start_round();
      repeat (3) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0);
      repeat (3) cyc(1, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd4 || score !== 3'd3 || high_score !== 3'd7) begin
         n_fail++;
         $display("FAIL round2: got st%0d sc%0d hi%0d want st4 sc3 hi7",
                  state, score, high_score);
      end
   endtask

   task automatic test_saturate;
      start_round();
      for (int i = 1; i <= 10; i++) begin
         cyc(0, 0, 0, 0, 1);
         n_tests++;
         if (score !== SW'((i > 7) ? 7 : i)) begin
            n_fail++;
            $display("FAIL sat%0d: got %0d want %0d", i, score, (i > 7) ? 7 : i);
         end
      end
      cyc(0, 0, 0, 1, 0);
      repeat (3) cyc(1, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd4 || high_score !== 3'd7) begin
         n_fail++;
         $display("FAIL sat_over: got st%0d hi%0d want st4 hi7", state, high_score);
      end
   endtask

   task automatic test_pause;
      start_round();
      cyc(0, 1, 0, 0, 0);
`ifdef PAUSE_TOGGLE_EN
      n_tests++;
      if (state !== 3'd5) begin
         n_fail++;
         $display("FAIL pause_enter: got %0d want 5", state);
      end
      for (int k = 0; k < 6; k++) begin
         cyc(1, 0, 1, (k == 2), 1);
         n_tests++;
         if (state !== 3'd5 || got_s !== 4'b0 || score !== 0) begin
            n_fail++;
            $display("FAIL paused%0d: got st%0d %b sc%0d want st5 0000 sc0",
                     k, state, got_s, score);
         end
      end
      cyc(0, 1, 0, 0, 0);
`endif
      n_tests++;
      if (state !== 3'd2) begin
         n_fail++;
         $display("FAIL pause_exit: got %0d want 2", state);
      end
      cyc(1, 0, 0, 0, 0);
      sb.push_back(strb_t'(4'b0100));
      cyc(1, 0, 0, 0, 0);
      exp_s = sb.pop_front();
      n_tests++;
      if (got_s !== exp_s) begin
         n_fail++;
         $display("FAIL pause_resume: got %b want %b", got_s, exp_s);
      end
   endtask

   task automatic test_reset_mid;
      repeat (5) cyc(0, 0, 0, 0, 1);
      n_tests++;
      if (score !== 3'd5) begin
         n_fail++;
         $display("FAIL pre_rst_score: got %0d want 5", score);
      end
      cyc(1, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(1, 1, 1, 0, 1);
      reset = 1'b0;
      n_tests++;
      if (state !== 0 || score !== 0 || high_score !== 0 ||
          got_s !== 4'b0 || done !== 0) begin
         n_fail++;
         $display("FAIL mid_rst: got st%0d sc%0d hi%0d %b d%0b want all 0",
                  state, score, high_score, got_s, done);
      end
      cyc(0, 0, 0, 0, 0);
      n_tests++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL post_rst: got %0d want 0", state);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_countdown();
      test_strobes();
      test_flap();
      test_score();
      test_round2();
      test_saturate();
      test_pause();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
